// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid-buffer occupancy states.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/pipe_slot.sv
// Enable-loaded register with synchronous clear; holds one {ctrl, data} entry.
module pipe_slot #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstn)     q <= '0;
        else if (clr)  q <= '0;
        else if (en)   q <= d;
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages; all outputs come from registers.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 16,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int SLOT_W = CTRL_W + DATA_W;

    buf_state_e        state_q, state_d;
    logic              accept, consume;
    logic              main_en, main_from_skid, main_clr;
    logic              skid_en, skid_clr;
    logic [SLOT_W-1:0] main_q, skid_q, main_d;

    // Handshakes depend on registered state only, so no ready path crosses the stage.
    assign accept  = in_valid  & (state_q != TWO);
    assign consume = out_ready & (state_q != EMPTY);

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE:     if (accept && !consume) state_d = TWO;
                         else if (!accept && consume) state_d = EMPTY;
                TWO:     if (consume) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready       = (state_q != TWO);
        out_valid      = (state_q != EMPTY);
        occupancy      = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY:   main_en = accept;
                ONE: begin
                    main_en = accept & consume;
                    skid_en = accept & ~consume;
                end
                TWO: begin
                    main_en        = consume;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
        // Payload wipe on empty only matters when the consumer wants a zero bubble.
        main_clr = CLEAR_DATA && (state_d == EMPTY);
        skid_clr = CLEAR_DATA && flush;
    end

    assign main_d = main_from_skid ? skid_q : {in_ctrl, in_data};

    pipe_slot #(.W(SLOT_W)) u_main (
        .clk (clk),
        .rstn(rstn),
        .clr (main_clr),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_slot #(.W(SLOT_W)) u_skid (
        .clk (clk),
        .rstn(rstn),
        .clr (skid_clr),
        .en  (skid_en),
        .d   ({in_ctrl, in_data}),
        .q   (skid_q)
    );

    assign out_ctrl = out_valid ? main_q[SLOT_W-1:DATA_W] : '0;
    assign out_data = main_q[DATA_W-1:0];

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed vector table plus random scoreboard run for the pipeline skid buffer.
module tb_pipe_stage_buf;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          ir0, ov0, ir1, ov1;
    logic [CW-1:0] oc0, oc1;
    logic [DW-1:0] od0, od1;
    logic [1:0]    occ0, occ1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0)) u_dut0 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
        .occupancy(occ0)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1)) u_dut1 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
        .occupancy(occ1)
    );

    typedef struct {
        logic          rstn, flush, iv;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic          ordy;
        logic          e_ov, e_ir;
        logic [1:0]    e_occ;
        logic [CW-1:0] e_ctrl;
        logic [DW-1:0] e_d0, e_d1;
    } vec_t;

    localparam int NV = 20;
    vec_t tv[NV];

    function automatic vec_t mk(logic r, logic f, logic iv, logic [CW-1:0] c, logic [DW-1:0] d,
                                logic ordy, logic e_ov, logic e_ir, logic [1:0] e_occ,
                                logic [CW-1:0] e_c, logic [DW-1:0] e_d0, logic [DW-1:0] e_d1);
        vec_t v;
        v.rstn = r; v.flush = f; v.iv = iv; v.ctrl = c; v.data = d; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_ctrl = e_c;
        v.e_d0 = e_d0; v.e_d1 = e_d1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_d;
    int            seq;
    int            guard;

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;

        //          rstn flush iv ctrl      data       ordy  ov ir occ ctrl     d0        d1
        tv[0]  = mk(0, 0, 0, 16'h0,  64'h0,   0,    0, 1, 0, 16'h0, 64'h0,   64'h0);
        tv[1]  = mk(1, 0, 1, 16'h3,  64'h10,  1,    1, 1, 1, 16'h3, 64'h10,  64'h10);
        tv[2]  = mk(1, 0, 0, 16'h0,  64'h0,   1,    0, 1, 0, 16'h0, 64'h10,  64'h0);
        tv[3]  = mk(1, 0, 1, 16'h1,  64'h100, 1,    1, 1, 1, 16'h1, 64'h100, 64'h100);
        tv[4]  = mk(1, 0, 1, 16'h2,  64'h104, 0,    1, 0, 2, 16'h1, 64'h100, 64'h100);
        tv[5]  = mk(1, 0, 1, 16'h7,  64'h108, 0,    1, 0, 2, 16'h1, 64'h100, 64'h100);
        tv[6]  = mk(1, 0, 0, 16'h0,  64'h0,   1,    1, 1, 1, 16'h2, 64'h104, 64'h104);
        tv[7]  = mk(1, 0, 0, 16'h0,  64'h0,   1,    0, 1, 0, 16'h0, 64'h104, 64'h0);
        tv[8]  = mk(1, 0, 1, 16'h4,  64'h300, 0,    1, 1, 1, 16'h4, 64'h300, 64'h300);
        tv[9]  = mk(1, 0, 1, 16'h5,  64'h304, 0,    1, 0, 2, 16'h4, 64'h300, 64'h300);
        tv[10] = mk(1, 1, 1, 16'h9,  64'h200, 0,    0, 1, 0, 16'h0, 64'h300, 64'h0);
        tv[11] = mk(1, 0, 0, 16'h0,  64'h0,   1,    0, 1, 0, 16'h0, 64'h300, 64'h0);
        tv[12] = mk(1, 0, 1, 16'h6,  64'h400, 0,    1, 1, 1, 16'h6, 64'h400, 64'h400);
        tv[13] = mk(1, 0, 1, 16'h6,  64'h404, 0,    1, 0, 2, 16'h6, 64'h400, 64'h400);
        tv[14] = mk(0, 1, 1, 16'h8,  64'h408, 1,    0, 1, 0, 16'h0, 64'h0,   64'h0);
        tv[15] = mk(1, 0, 0, 16'h0,  64'h0,   1,    0, 1, 0, 16'h0, 64'h0,   64'h0);
        tv[16] = mk(1, 0, 1, 16'h1,  64'h500, 1,    1, 1, 1, 16'h1, 64'h500, 64'h500);
        tv[17] = mk(1, 0, 1, 16'h2,  64'h504, 1,    1, 1, 1, 16'h2, 64'h504, 64'h504);
        tv[18] = mk(1, 0, 0, 16'h0,  64'h0,   0,    1, 1, 1, 16'h2, 64'h504, 64'h504);
        tv[19] = mk(1, 0, 0, 16'h0,  64'h0,   1,    0, 1, 0, 16'h0, 64'h504, 64'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rstn = tv[i].rstn; flush = tv[i].flush; in_valid = tv[i].iv;
            in_ctrl = tv[i].ctrl; in_data = tv[i].data; out_ready = tv[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d out_valid", i), 64'(ov0),  64'(tv[i].e_ov));
            chk($sformatf("v%0d in_ready", i),  64'(ir0),  64'(tv[i].e_ir));
            chk($sformatf("v%0d occupancy", i), 64'(occ0), 64'(tv[i].e_occ));
            chk($sformatf("v%0d out_ctrl", i),  64'(oc0),  64'(tv[i].e_ctrl));
            chk($sformatf("v%0d out_data", i),  od0,       tv[i].e_d0);
            chk($sformatf("v%0d out_data_clr", i), od1,    tv[i].e_d1);
            chk($sformatf("v%0d out_ctrl_clr", i), 64'(oc1), 64'(tv[i].e_ctrl));
        end

        // Random handshakes; each accepted word carries a sequence number in its low half.
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; rstn = 1'b1;
        seq = 0;
        @(negedge clk);
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, 32'(seq)};
            #1;
            if (occ0 == 2'd2) chk("rand in_ready in TWO", 64'(ir0), 64'd0);
            if (!ov0)         chk("rand bubble ctrl", 64'(oc0), 64'd0);
            if (ov0 && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rand spurious output", 64'(ov0), 64'd0);
                end else begin
                    exp_d = sb.pop_front();
                    chk("rand order", od0, exp_d);
                end
            end
            if (in_valid && ir0) begin
                sb.push_back(in_data);
                seq++;
            end
            @(negedge clk);
        end

        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (ov0 && guard < 10) begin
            if (sb.size() != 0) begin
                exp_d = sb.pop_front();
                chk("drain order", od0, exp_d);
            end else begin
                chk("drain extra output", 64'(ov0), 64'd0);
            end
            @(negedge clk);
            guard++;
        end
        chk("drain bound", 64'(ov0), 64'd0);
        chk("no loss", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload width (PC, immediate, operands), legal range 1..256.
REQ-002 SHALL have parameter CTRL_W, default 16, meaning control-field width (write enables, func selects); legal range 1..64.
REQ-003 SHALL have parameter CLEAR_DATA, default 0, meaning 1 = payload also forced to zero when slot empty or flushed.
REQ-004 SHALL have port clk, input, 1, meaning rising-edge clock.
REQ-005 SHALL have port rstn, input, 1, meaning reset, synchronous, active-low.
REQ-006 SHALL have port flush, input, 1, meaning kill all held entries (branch/jump redirect).
REQ-007 SHALL have port in_valid, input, 1, meaning upstream stage holds an instruction.
REQ-008 SHALL have port in_ready, output, 1, meaning block can accept an input this cycle.
REQ-009 SHALL have port in_ctrl, input, CTRL_W, meaning upstream control fields.
REQ-010 SHALL have port in_data, input, DATA_W, meaning upstream payload.
REQ-011 SHALL have port out_valid, output, 1, meaning downstream stage receives an instruction.
REQ-012 SHALL have port out_ready, input, 1, meaning downstream consumes out this cycle.
REQ-013 SHALL have port out_ctrl, output, CTRL_W, meaning held control fields, zero when not out_valid.
REQ-014 SHALL have port out_data, output, DATA_W, meaning held payload.
REQ-015 SHALL have port occupancy, output, 2, meaning entries held (0..2).

Function
REQ-016 SHALL implement a two-entry skid buffer: main slot drives outputs, skid slot absorbs one input when downstream stalls.
REQ-017 SHALL use states EMPTY (0 entries), ONE (main valid), TWO (main+skid valid); occupancy equals state count.
REQ-018 SHALL define accept = in_valid & in_ready and consume = out_valid & out_ready.
REQ-019 SHALL drive in_ready = (state != TWO), from registered state only (no combinational path from out_ready).
REQ-020 SHALL drive out_valid = (state != EMPTY); out_ctrl/out_data from main slot, no combinational input-to-output path.
REQ-021 SHALL transition EMPTY: accept -> ONE, main <= in.
REQ-022 SHALL transition ONE: accept & consume -> ONE, main <= in; accept & !consume -> TWO, skid <= in; !accept & consume -> EMPTY; else hold.
REQ-023 SHALL transition TWO: consume -> ONE, main <= skid; else hold; no accept possible.
REQ-024 SHALL preserve strict FIFO order; latency in-to-out exactly 1 cycle when no stall.
REQ-025 SHALL, on flush, go to EMPTY next edge, discarding main, skid, and any same-cycle accepted input; flush overrides all transitions.
REQ-026 SHALL force out_ctrl to zero whenever out_valid = 0 (bubble never asserts write enables).
REQ-027 SHALL hold out_data unchanged when empty if CLEAR_DATA = 0; SHALL zero it when CLEAR_DATA = 1.
REQ-028 SHALL keep all outputs stable while out_valid & !out_ready.

Reset
REQ-029 SHALL, when rstn = 0 at a clock edge, enter EMPTY, zero both slots' ctrl and data; reset has priority over flush.
REQ-030 SHALL present after reset: in_ready = 1, out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0.
REQ-031 SHALL discard held entries on reset mid-operation; no input accepted during a reset cycle.

Structure
REQ-032 SHALL take state encodings (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) from shared package pipe_pkg.
REQ-033 SHALL instantiate sub-module pipe_slot (enable-loaded, clearable CTRL_W+DATA_W register) twice: main and skid.

Verification
REQ-034 Bench SHALL check: reset, then in_valid=1 data 0x00000010 ctrl 0x0003, out_ready=1 -> next cycle out_valid=1, out_data=0x00000010, occupancy=1.
REQ-035 Bench SHALL check: stream A=0x100, B=0x104 with out_ready=0 from B's cycle -> occupancy=2, in_ready=0, out_data=0x100; release -> 0x100 then 0x104, in order.
REQ-036 Bench SHALL check: TWO state, flush=1 with in_valid=1 data 0x200 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, 0x200 never emitted.
REQ-037 Bench SHALL check: CLEAR_DATA=1, drain to EMPTY -> out_data=0; CLEAR_DATA=0 -> out_data holds last value, out_ctrl=0.
REQ-038 Bench SHALL check: rstn=0 while occupancy=2 -> next cycle all outputs at REQ-030 values.
REQ-039 Bench SHALL check: random in_valid/out_ready, 10000 cycles, DATA_W=64 -> scoreboard order match, no loss/duplication, in_ready never 1 in TWO.
